// File: rtl/mem_writeback_if.sv
// Single-port data-memory request/response bus between the writeback stage
// (master) and the data memory (slave).
interface mem_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input  ready, rvalid, rdata);
  modport slave  (input  req, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_writeback.sv
// Memory-access + writeback stage of the 4-slot VLIW core: serialises slot 3/4
// memory ops on one port, then commits the bundle atomically on wb_*.
// Optional: STORE_LOAD_FWD_EN forwards a slot-3 store to a same-address slot-4 load.
module mem_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int RD_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_res1,
  input  logic [DATA_W-1:0] ex_res2,
  input  logic [RD_W-1:0]   ex_rd1,
  input  logic [RD_W-1:0]   ex_rd2,
  input  logic [RD_W-1:0]   ex_rd3,
  input  logic [RD_W-1:0]   ex_rd4,
  input  logic              ex_mre3,
  input  logic              ex_mwe3,
  input  logic              ex_mre4,
  input  logic              ex_mwe4,
  input  logic [ADDR_W-1:0] ex_daddr3,
  input  logic [ADDR_W-1:0] ex_daddr4,
  input  logic [DATA_W-1:0] ex_sdata3,
  input  logic [DATA_W-1:0] ex_sdata4,
  mem_writeback_if.master   m,
  output logic [RD_W-1:0]   wb_rd1,
  output logic [RD_W-1:0]   wb_rd2,
  output logic [RD_W-1:0]   wb_rd3,
  output logic [RD_W-1:0]   wb_rd4,
  output logic [DATA_W-1:0] wb_res1,
  output logic [DATA_W-1:0] wb_res2,
  output logic [DATA_W-1:0] wb_memdata3,
  output logic [DATA_W-1:0] wb_memdata4,
  output logic              mem_stall
);

  typedef enum logic [2:0] {IDLE, REQ3, WAIT3, REQ4, WAIT4} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] res1, res2;
    logic [RD_W-1:0]   rd1, rd2, rd3, rd4;
    logic              mre3, mwe3, mre4, mwe4;
    logic [ADDR_W-1:0] addr3, addr4;
    logic [DATA_W-1:0] sdata3, sdata4;
  } bundle_t;

  state_t            state, state_d;
  bundle_t           ex_b, cap, b;
  logic [DATA_W-1:0] ld3_data;
  logic              op3, ld3, st3, op4, ld4, st4;
  logic              fwd, need4, commit;
  logic [DATA_W-1:0] md3, md4;

  always_comb begin
    ex_b        = '0;
    ex_b.res1   = ex_res1;
    ex_b.res2   = ex_res2;
    ex_b.rd1    = ex_rd1;
    ex_b.rd2    = ex_rd2;
    ex_b.rd3    = ex_rd3;
    ex_b.rd4    = ex_rd4;
    ex_b.mre3   = ex_mre3;
    ex_b.mwe3   = ex_mwe3;
    ex_b.mre4   = ex_mre4;
    ex_b.mwe4   = ex_mwe4;
    ex_b.addr3  = ex_daddr3;
    ex_b.addr4  = ex_daddr4;
    ex_b.sdata3 = ex_sdata3;
    ex_b.sdata4 = ex_sdata4;
  end

  // In IDLE the live ex_* bundle drives decisions; afterwards only the captured copy.
  assign b   = (state == IDLE) ? ex_b : cap;
  assign op3 = b.mre3 | b.mwe3;
  assign ld3 = b.mre3;
  assign st3 = b.mwe3 & ~b.mre3;
  assign op4 = b.mre4 | b.mwe4;
  assign ld4 = b.mre4;
  assign st4 = b.mwe4 & ~b.mre4;

`ifdef STORE_LOAD_FWD_EN
  assign fwd = st3 & ld4 & (b.addr3 == b.addr4);
`else
  assign fwd = 1'b0;
`endif
  assign need4 = op4 & ~fwd;

  always_comb begin
    state_d = state;
    commit  = 1'b0;
    unique case (state)
      IDLE:  if (ex_valid) begin
               if (op3)        state_d = REQ3;
               else if (need4) state_d = REQ4;
               else            commit  = 1'b1;
             end
      REQ3:  if (m.ready) begin
               if (ld3)        state_d = WAIT3;
               else if (need4) state_d = REQ4;
               else            commit  = 1'b1;
             end
      WAIT3: if (m.rvalid) begin
               if (need4) state_d = REQ4;
               else       commit  = 1'b1;
             end
      REQ4:  if (m.ready) begin
               if (ld4) state_d = WAIT4;
               else     commit  = 1'b1;
             end
      WAIT4: if (m.rvalid) commit = 1'b1;
      default: state_d = IDLE;
    endcase
    if (commit) state_d = IDLE;
  end

  assign mem_stall = (state == IDLE) ? (ex_valid & (op3 | op4)) : ~commit;

  always_comb begin
    m.req   = 1'b0;
    m.we    = 1'b0;
    m.addr  = '0;
    m.wdata = '0;
    unique case (state)
      REQ3: begin
        m.req   = 1'b1;
        m.we    = st3;
        m.addr  = cap.addr3;
        m.wdata = cap.sdata3;
      end
      REQ4: begin
        m.req   = 1'b1;
        m.we    = st4;
        m.addr  = cap.addr4;
        m.wdata = cap.sdata4;
      end
      default: ;
    endcase
  end

  // Slot-3 load data comes straight off the bus if slot 3 is the last op.
  assign md3 = !ld3 ? '0 : (state == WAIT3) ? m.rdata : ld3_data;
  assign md4 = !ld4 ? '0 : fwd ? b.sdata3 : m.rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap         <= '0;
      ld3_data    <= '0;
      wb_rd1      <= '0;
      wb_rd2      <= '0;
      wb_rd3      <= '0;
      wb_rd4      <= '0;
      wb_res1     <= '0;
      wb_res2     <= '0;
      wb_memdata3 <= '0;
      wb_memdata4 <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && ex_valid) cap      <= ex_b;
      if (state == WAIT3 && m.rvalid) ld3_data <= m.rdata;
      // Store slots carry no register result, so their tag is suppressed.
      wb_rd1      <= commit ? b.rd1 : '0;
      wb_rd2      <= commit ? b.rd2 : '0;
      wb_rd3      <= (commit && !st3) ? b.rd3 : '0;
      wb_rd4      <= (commit && !st4) ? b.rd4 : '0;
      wb_res1     <= commit ? b.res1 : '0;
      wb_res2     <= commit ? b.res2 : '0;
      wb_memdata3 <= commit ? md3 : '0;
      wb_memdata4 <= commit ? md4 : '0;
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Randomised scoreboard bench for mem_writeback: a memory responder and a
// commit monitor check the DUT against a bundle-level reference model.
module tb_mem_writeback;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int RW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ex_valid;
  logic [DW-1:0] ex_res1, ex_res2, ex_sdata3, ex_sdata4;
  logic [RW-1:0] ex_rd1, ex_rd2, ex_rd3, ex_rd4;
  logic          ex_mre3, ex_mwe3, ex_mre4, ex_mwe4;
  logic [AW-1:0] ex_daddr3, ex_daddr4;
  logic [RW-1:0] wb_rd1, wb_rd2, wb_rd3, wb_rd4;
  logic [DW-1:0] wb_res1, wb_res2, wb_memdata3, wb_memdata4;
  logic          mem_stall;

  mem_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

  mem_writeback #(.DATA_W(DW), .ADDR_W(AW), .RD_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .ex_res1(ex_res1), .ex_res2(ex_res2),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_rd3(ex_rd3), .ex_rd4(ex_rd4),
    .ex_mre3(ex_mre3), .ex_mwe3(ex_mwe3), .ex_mre4(ex_mre4), .ex_mwe4(ex_mwe4),
    .ex_daddr3(ex_daddr3), .ex_daddr4(ex_daddr4),
    .ex_sdata3(ex_sdata3), .ex_sdata4(ex_sdata4),
    .m(mif),
    .wb_rd1(wb_rd1), .wb_rd2(wb_rd2), .wb_rd3(wb_rd3), .wb_rd4(wb_rd4),
    .wb_res1(wb_res1), .wb_res2(wb_res2),
    .wb_memdata3(wb_memdata3), .wb_memdata4(wb_memdata4),
    .mem_stall(mem_stall)
  );

  // op encoding: 0 none, 1 load, 2 store, 3 load+store (acts as load)
  typedef struct packed {
    logic [DW-1:0] res1, res2, sd3, sd4;
    logic [RW-1:0] rd1, rd2, rd3, rd4;
    logic [1:0]    op3, op4;
    logic [AW-1:0] addr3, addr4;
  } bnd_t;

  typedef struct packed {
    logic [RW-1:0] rd1, rd2, rd3, rd4;
    logic [DW-1:0] res1, res2, md3, md4;
  } wb_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  wb_t  exp_wb_q[$];
  req_t exp_req_q[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];

  int checks = 0;
  int failures = 0;
  int fix_rdy = -1;
  int fix_rv = -1;
  bit hold_rv = 1'b0;
  bit kick_rv = 1'b0;
  bit aborted = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic flag_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (event not expected at t=%0t)", nm, $time);
  endtask

  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    return {2'b01, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : mem_init(a);
  endfunction

  // Reference model: ops execute in slot order against a flat memory image;
  // the commit carries load data, stores contribute no tag.
  task automatic issue(input bnd_t b, output wb_t e, output bit anymem);
    bit ld3, st3, ld4, st4, fwd;
    req_t r;
    ld3 = (b.op3 == 2'd1) || (b.op3 == 2'd3);
    st3 = (b.op3 == 2'd2);
    ld4 = (b.op4 == 2'd1) || (b.op4 == 2'd3);
    st4 = (b.op4 == 2'd2);
    anymem = (b.op3 != 2'd0) || (b.op4 != 2'd0);
`ifdef STORE_LOAD_FWD_EN
    fwd = st3 && ld4 && (b.addr3 == b.addr4);
`else
    fwd = 1'b0;
`endif
    e = '0;
    e.rd1 = b.rd1; e.rd2 = b.rd2; e.res1 = b.res1; e.res2 = b.res2;
    e.rd3 = st3 ? '0 : b.rd3;
    e.rd4 = st4 ? '0 : b.rd4;
    if (ld3) begin
      r = '{we: 1'b0, addr: b.addr3, wdata: '0};
      exp_req_q.push_back(r);
      e.md3 = ref_rd(b.addr3);
    end else if (st3) begin
      r = '{we: 1'b1, addr: b.addr3, wdata: b.sd3};
      exp_req_q.push_back(r);
      ref_mem[b.addr3] = b.sd3;
    end
    if (ld4) begin
      if (fwd) e.md4 = b.sd3;
      else begin
        r = '{we: 1'b0, addr: b.addr4, wdata: '0};
        exp_req_q.push_back(r);
        e.md4 = ref_rd(b.addr4);
      end
    end else if (st4) begin
      r = '{we: 1'b1, addr: b.addr4, wdata: b.sd4};
      exp_req_q.push_back(r);
      ref_mem[b.addr4] = b.sd4;
    end
    exp_wb_q.push_back(e);
  endtask

  task automatic drive(input bnd_t b);
    ex_res1 = b.res1; ex_res2 = b.res2; ex_sdata3 = b.sd3; ex_sdata4 = b.sd4;
    ex_rd1 = b.rd1; ex_rd2 = b.rd2; ex_rd3 = b.rd3; ex_rd4 = b.rd4;
    ex_mre3 = b.op3[0]; ex_mwe3 = b.op3[1];
    ex_mre4 = b.op4[0]; ex_mwe4 = b.op4[1];
    ex_daddr3 = b.addr3; ex_daddr4 = b.addr4;
  endtask

  task automatic scramble();
    ex_res1 = $urandom; ex_res2 = $urandom; ex_sdata3 = $urandom; ex_sdata4 = $urandom;
    ex_rd1 = RW'($urandom); ex_rd3 = RW'($urandom);
    ex_mre3 = 1'($urandom); ex_mwe4 = 1'($urandom);
    ex_daddr3 = AW'($urandom); ex_daddr4 = AW'($urandom);
  endtask

  task automatic run_bundle(input bnd_t b);
    wb_t e;
    bit anym, st;
    int cyc;
    issue(b, e, anym);
    @(negedge clk);
    drive(b);
    ex_valid = 1'b1;
    #4;
    st = mem_stall;
    chk("stall_first", 256'(st), 256'(anym));
    cyc = 0;
    while (st) begin
      @(negedge clk);
      scramble();
      #4;
      st = mem_stall;
      cyc++;
      if (cyc > 200) begin
        flag_fail("stall_timeout");
        aborted = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    chk("commit_align_rd1", 256'(wb_rd1), 256'(e.rd1));
  endtask

  task automatic rand_bundle(output bnd_t b);
    b.res1 = $urandom; b.res2 = $urandom; b.sd3 = $urandom; b.sd4 = $urandom;
    b.rd1 = {1'b1, 6'($urandom)};
    b.rd2 = RW'($urandom); b.rd3 = RW'($urandom); b.rd4 = RW'($urandom);
    b.op3 = 2'($urandom_range(0, 3));
    b.op4 = 2'($urandom_range(0, 3));
    b.addr3 = AW'($urandom_range(0, 7));
    b.addr4 = ($urandom_range(0, 3) == 0) ? b.addr3 : AW'($urandom_range(0, 7));
  endtask

  // Memory responder: random accept latency, read data 1+ cycles after accept.
  initial begin : responder
    int wt, cnt;
    bit seen, pend;
    logic [AW-1:0] pa;
    req_t r;
    wt = 0; cnt = 0; seen = 0; pend = 0; pa = '0;
    mif.ready = 1'b0; mif.rvalid = 1'b0; mif.rdata = '0;
    forever begin
      @(negedge clk);
      mif.ready = 1'b0;
      mif.rvalid = 1'b0;
      mif.rdata = $urandom;
      if (!rst_n) begin
        pend = 0; seen = 0;
      end else if (kick_rv) begin
        kick_rv = 1'b0;
        pend = 0;
        mif.rvalid = 1'b1;
      end else if (pend) begin
        if (!hold_rv) begin
          if (cnt == 0) begin
            mif.rvalid = 1'b1;
            mif.rdata = mem_rd(pa);
            pend = 0;
          end else cnt--;
        end
      end else if (mif.req) begin
        if (exp_req_q.size() == 0) flag_fail("req_unexpected");
        else begin
          r = exp_req_q[0];
          chk("req_we", 256'(mif.we), 256'(r.we));
          chk("req_addr", 256'(mif.addr), 256'(r.addr));
          if (r.we) chk("req_wdata", 256'(mif.wdata), 256'(r.wdata));
        end
        if (!seen) begin
          seen = 1;
          wt = (fix_rdy >= 0) ? fix_rdy : $urandom_range(0, 3);
        end
        if (wt == 0) begin
          mif.ready = 1'b1;
          seen = 0;
          if (mif.we) mem[mif.addr] = mif.wdata;
          else begin
            pend = 1;
            pa = mif.addr;
            cnt = (fix_rv >= 0) ? fix_rv : $urandom_range(0, 3);
          end
          if (exp_req_q.size() != 0) void'(exp_req_q.pop_front());
        end else wt--;
      end
    end
  end

  // Commit monitor: every non-zero wb_rd1 is a commit (bench always sets rd1[6]).
  initial begin : monitor
    wb_t e, act;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        act = '{rd1: wb_rd1, rd2: wb_rd2, rd3: wb_rd3, rd4: wb_rd4,
                res1: wb_res1, res2: wb_res2, md3: wb_memdata3, md4: wb_memdata4};
        if (wb_rd1 != '0) begin
          if (exp_wb_q.size() == 0) flag_fail("wb_unexpected_commit");
          else begin
            e = exp_wb_q.pop_front();
            chk("wb_commit", 256'(act), 256'(e));
          end
        end else begin
          chk("wb_idle_zero", 256'(act), 256'(0));
        end
      end
    end
  end

  initial begin : main
    bnd_t b;
    ex_valid = 1'b0;
    scramble();
    ex_rd1 = '0; ex_rd2 = '0; ex_rd4 = '0;
    ex_mre3 = 1'b0; ex_mwe3 = 1'b0; ex_mre4 = 1'b0; ex_mwe4 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb", 256'({wb_rd1, wb_rd2, wb_rd3, wb_rd4, wb_res1, wb_res2, wb_memdata3, wb_memdata4}), 256'(0));
    chk("rst_mreq", 256'({mif.req, mif.we, mif.addr, mif.wdata}), 256'(0));
    chk("rst_stall", 256'(mem_stall), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // ALU-only bundle
    b = '0; b.rd1 = 7'h45; b.res1 = 32'h1234;
    run_bundle(b);
    // slot-3 load, immediate accept, data two cycles after accept
    mem[30'h10] = 32'hDEADBEEF; ref_mem[30'h10] = 32'hDEADBEEF;
    fix_rdy = 0; fix_rv = 1;
    b = '0; b.rd1 = 7'h41; b.rd3 = 7'h43; b.op3 = 2'd1; b.addr3 = 30'h10;
    run_bundle(b);
    // store + load to different addresses, slow accept
    fix_rdy = 3; fix_rv = -1;
    b = '0; b.rd1 = 7'h42; b.rd3 = 7'h4A; b.rd4 = 7'h4B; b.op3 = 2'd2; b.op4 = 2'd1;
    b.addr3 = 30'h20; b.addr4 = 30'h21; b.sd3 = 32'h1111_2222;
    run_bundle(b);
    // store then load of the same address in one bundle
    fix_rdy = -1;
    b = '0; b.rd1 = 7'h50; b.rd4 = 7'h54; b.op3 = 2'd2; b.op4 = 2'd1;
    b.addr3 = 30'h5; b.addr4 = 30'h5; b.sd3 = 32'hCAFE;
    run_bundle(b);

    for (int i = 0; i < 200 && !aborted; i++) begin
      rand_bundle(b);
      run_bundle(b);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        scramble();
      end
    end

    repeat (3) @(negedge clk);
    chk("wb_q_empty", 256'(exp_wb_q.size()), 256'(0));
    chk("req_q_empty", 256'(exp_req_q.size()), 256'(0));

    if (!aborted) begin
      // reset while waiting for slot-3 read data
      fix_rdy = 0; hold_rv = 1'b1;
      @(negedge clk);
      b = '0; b.rd1 = 7'h7F; b.rd3 = 7'h73; b.op3 = 2'd1; b.addr3 = 30'h2;
      drive(b);
      ex_valid = 1'b1;
      exp_req_q.push_back('{we: 1'b0, addr: 30'h2, wdata: '0});
      @(negedge clk);
      ex_valid = 1'b0;
      @(negedge clk);
      #2;
      chk("pre_rst_stall", 256'(mem_stall), 256'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_stall", 256'(mem_stall), 256'(0));
      chk("mid_rst_mreq", 256'({mif.req, mif.we, mif.addr, mif.wdata}), 256'(0));
      chk("mid_rst_wb", 256'({wb_rd1, wb_rd2, wb_rd3, wb_rd4, wb_memdata3}), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      kick_rv = 1'b1;
      hold_rv = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        #1;
        chk("post_rst_no_commit", 256'({wb_rd1, wb_rd3, wb_memdata3}), 256'(0));
        chk("post_rst_idle", 256'({mem_stall, mif.req}), 256'(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
